// File: rtl/aximm_leader_traffic_gen.sv
// AXI4-MM leader traffic generator/checker: independent write and read engines
// driving a seeded incrementing pattern and checking it on read-back.
module aximm_leader_traffic_gen #(
    parameter int          DWIDTH    = 128,
    parameter int          ADDRWIDTH = 32,
    parameter int          IDWIDTH   = 4,
    parameter int unsigned ID_VALUE  = 0,
    parameter int          CNTWIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            cfg_len,
    input  logic [ADDRWIDTH-1:0]  cfg_addr,
    input  logic [31:0]           cfg_seed,
    input  logic                  wr_start,
    input  logic                  rd_start,
    output logic                  wr_busy,
    output logic                  rd_busy,
    output logic                  wr_done,
    output logic                  rd_done,
    output logic [1:0]            wr_resp,
    output logic                  rd_resp_err,
    output logic                  rd_len_err,
    output logic [CNTWIDTH-1:0]   rd_mismatch_cnt,
    output logic [IDWIDTH-1:0]    user_awid,
    output logic [ADDRWIDTH-1:0]  user_awaddr,
    output logic [7:0]            user_awlen,
    output logic [2:0]            user_awsize,
    output logic [1:0]            user_awburst,
    output logic                  user_awvalid,
    input  logic                  user_awready,
    output logic [IDWIDTH-1:0]    user_wid,
    output logic [DWIDTH-1:0]     user_wdata,
    output logic [DWIDTH/8-1:0]   user_wstrb,
    output logic                  user_wlast,
    output logic                  user_wvalid,
    input  logic                  user_wready,
    input  logic [IDWIDTH-1:0]    user_bid,
    input  logic [1:0]            user_bresp,
    input  logic                  user_bvalid,
    output logic                  user_bready,
    output logic [IDWIDTH-1:0]    user_arid,
    output logic [ADDRWIDTH-1:0]  user_araddr,
    output logic [7:0]            user_arlen,
    output logic [2:0]            user_arsize,
    output logic [1:0]            user_arburst,
    output logic                  user_arvalid,
    input  logic                  user_arready,
    input  logic [IDWIDTH-1:0]    user_rid,
    input  logic [DWIDTH-1:0]     user_rdata,
    input  logic [1:0]            user_rresp,
    input  logic                  user_rlast,
    input  logic                  user_rvalid,
    output logic                  user_rready
);

    localparam int unsigned NWORDS = DWIDTH / 32;
    localparam logic [2:0]  AXSIZE = 3'($clog2(DWIDTH / 8));

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [7:0]           w_len, w_cnt, r_len;
    logic [ADDRWIDTH-1:0] w_addr, r_addr;
    logic [31:0]          w_seed, r_seed;
    logic [8:0]           r_cnt;
    logic [DWIDTH-1:0]    r_exp;

    // Response IDs are not checked; the engines use a single fixed ID.
    logic unused_ids;
    assign unused_ids = ^{user_bid, user_rid};

    assign user_awid    = IDWIDTH'(ID_VALUE);
    assign user_wid     = IDWIDTH'(ID_VALUE);
    assign user_arid    = IDWIDTH'(ID_VALUE);
    assign user_awsize  = AXSIZE;
    assign user_arsize  = AXSIZE;
    assign user_awburst = 2'b01;
    assign user_arburst = 2'b01;
    assign user_wstrb   = '1;
    assign user_awaddr  = w_addr;
    assign user_awlen   = w_len;
    assign user_araddr  = r_addr;
    assign user_arlen   = r_len;
    assign user_wdata   = {NWORDS{w_seed + 32'(w_cnt)}};
    assign user_wlast   = (w_cnt == w_len);
    assign r_exp        = {NWORDS{r_seed + 32'(r_cnt)}};
    assign wr_busy      = (w_state != W_IDLE);
    assign rd_busy      = (r_state != R_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next       = w_state;
        user_awvalid = 1'b0;
        user_wvalid  = 1'b0;
        user_bready  = 1'b0;
        case (w_state)
            W_IDLE: if (wr_start) w_next = W_ADDR;
            W_ADDR: begin
                user_awvalid = 1'b1;
                if (user_awready) w_next = W_DATA;
            end
            W_DATA: begin
                user_wvalid = 1'b1;
                if (user_wready && user_wlast) w_next = W_RESP;
            end
            W_RESP: begin
                user_bready = 1'b1;
                if (user_bvalid) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next       = r_state;
        user_arvalid = 1'b0;
        user_rready  = 1'b0;
        case (r_state)
            R_IDLE: if (rd_start) r_next = R_ADDR;
            R_ADDR: begin
                user_arvalid = 1'b1;
                if (user_arready) r_next = R_DATA;
            end
            R_DATA: begin
                user_rready = 1'b1;
                if (user_rvalid && user_rlast) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_len   <= '0;
            w_addr  <= '0;
            w_seed  <= '0;
            w_cnt   <= '0;
            wr_done <= 1'b0;
            wr_resp <= '0;
        end else begin
            wr_done <= 1'b0;
            if (w_state == W_IDLE && wr_start) begin
                w_len  <= cfg_len;
                w_addr <= cfg_addr;
                w_seed <= cfg_seed;
                w_cnt  <= '0;
            end
            if (w_state == W_DATA && user_wready) w_cnt <= w_cnt + 8'd1;
            if (w_state == W_RESP && user_bvalid) begin
                wr_resp <= user_bresp;
                wr_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len           <= '0;
            r_addr          <= '0;
            r_seed          <= '0;
            r_cnt           <= '0;
            rd_done         <= 1'b0;
            rd_resp_err     <= 1'b0;
            rd_len_err      <= 1'b0;
            rd_mismatch_cnt <= '0;
        end else begin
            rd_done <= 1'b0;
            if (r_state == R_IDLE && rd_start) begin
                r_len           <= cfg_len;
                r_addr          <= cfg_addr;
                r_seed          <= cfg_seed;
                r_cnt           <= '0;
                rd_resp_err     <= 1'b0;
                rd_len_err      <= 1'b0;
                rd_mismatch_cnt <= '0;
            end
            if (r_state == R_DATA && user_rvalid) begin
                if (user_rdata != r_exp && rd_mismatch_cnt != '1)
                    rd_mismatch_cnt <= rd_mismatch_cnt + 1'b1;
                if (user_rresp != 2'b00) rd_resp_err <= 1'b1;
                // Count saturates so an overlong burst keeps flagging a length error.
                if (r_cnt != '1) r_cnt <= r_cnt + 9'd1;
                if (r_cnt > {1'b0, r_len} || (user_rlast && r_cnt != {1'b0, r_len}))
                    rd_len_err <= 1'b1;
                if (user_rlast) rd_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aximm_leader_traffic_gen.sv
// Directed bench for aximm_leader_traffic_gen: vector table of write/read bursts
// against a behavioural subordinate, plus busy, concurrency and reset sequences.
module tb_aximm_leader_traffic_gen;

    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    cfg_len = '0;
    logic [31:0]   cfg_addr = '0;
    logic [31:0]   cfg_seed = '0;
    logic          wr_start = 1'b0, rd_start = 1'b0;
    logic          wr_busy, rd_busy, wr_done, rd_done;
    logic [1:0]    wr_resp;
    logic          rd_resp_err, rd_len_err;
    logic [15:0]   rd_mismatch_cnt;
    logic [3:0]    user_awid, user_wid, user_arid;
    logic [31:0]   user_awaddr, user_araddr;
    logic [7:0]    user_awlen, user_arlen;
    logic [2:0]    user_awsize, user_arsize;
    logic [1:0]    user_awburst, user_arburst;
    logic          user_awvalid, user_wvalid, user_wlast, user_arvalid;
    logic          user_bready, user_rready;
    logic [DW-1:0] user_wdata;
    logic [DW/8-1:0] user_wstrb;
    logic          user_awready = 1'b0, user_wready = 1'b0, user_arready = 1'b0;
    logic [3:0]    user_bid = '0, user_rid = '0;
    logic [1:0]    user_bresp = '0, user_rresp = '0;
    logic          user_bvalid = 1'b0, user_rvalid = 1'b0, user_rlast = 1'b0;
    logic [DW-1:0] user_rdata = '0;

    int checks = 0;
    int errors = 0;
    int cur_vec = -1;

    aximm_leader_traffic_gen #(
        .DWIDTH(DW), .ADDRWIDTH(32), .IDWIDTH(4), .ID_VALUE(0), .CNTWIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .cfg_addr(cfg_addr), .cfg_seed(cfg_seed),
        .wr_start(wr_start), .rd_start(rd_start), .wr_busy(wr_busy), .rd_busy(rd_busy),
        .wr_done(wr_done), .rd_done(rd_done), .wr_resp(wr_resp), .rd_resp_err(rd_resp_err),
        .rd_len_err(rd_len_err), .rd_mismatch_cnt(rd_mismatch_cnt),
        .user_awid(user_awid), .user_awaddr(user_awaddr), .user_awlen(user_awlen),
        .user_awsize(user_awsize), .user_awburst(user_awburst), .user_awvalid(user_awvalid),
        .user_awready(user_awready),
        .user_wid(user_wid), .user_wdata(user_wdata), .user_wstrb(user_wstrb),
        .user_wlast(user_wlast), .user_wvalid(user_wvalid), .user_wready(user_wready),
        .user_bid(user_bid), .user_bresp(user_bresp), .user_bvalid(user_bvalid),
        .user_bready(user_bready),
        .user_arid(user_arid), .user_araddr(user_araddr), .user_arlen(user_arlen),
        .user_arsize(user_arsize), .user_arburst(user_arburst), .user_arvalid(user_arvalid),
        .user_arready(user_arready),
        .user_rid(user_rid), .user_rdata(user_rdata), .user_rresp(user_rresp),
        .user_rlast(user_rlast), .user_rvalid(user_rvalid), .user_rready(user_rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_rd;
        logic [7:0]  len;
        logic [31:0] addr;
        logic [31:0] seed;
        bit          stall;
        int          bad_beat;
        int          last_beat;
        int          err_beat;
        logic [1:0]  bresp;
        int          exp_beats;
        logic [1:0]  exp_wr_resp;
        int          exp_mis;
        bit          exp_len_err;
        bit          exp_resp_err;
    } vec_t;

    localparam int NV = 11;
    vec_t tv [NV];

    function automatic logic [DW-1:0] pat(input logic [31:0] w);
        return {(DW/32){w}};
    endfunction

    task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got %0h, expected %0h", name, cur_vec, act, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] len, input logic [31:0] addr, input logic [31:0] seed,
                            input bit stall, input logic [1:0] bresp, input bit dup,
                            output int beats, output int aw_hs, output logic [1:0] resp_seen,
                            output int dones);
        bit held = 0;
        logic [DW:0] hold = '0;
        beats = 0; aw_hs = 0; dones = 0; resp_seen = 2'bxx;
        @(negedge clk);
        cfg_len = len; cfg_addr = addr; cfg_seed = seed; wr_start = 1'b1;
        @(negedge clk);
        wr_start = 1'b0;
        check("wr_busy_after_start", wr_busy, 1);
        user_awready = 1'b1;
        for (int cyc = 0; cyc < 300 && dones == 0; cyc++) begin
            if (wr_done) begin dones++; resp_seen = wr_resp; end
            wr_start = (dup && cyc == 2);
            if (user_awvalid) begin
                check("awaddr", user_awaddr, addr);
                check("awlen", user_awlen, len);
                aw_hs++;
            end
            if (user_wvalid) begin
                check("w_after_aw", (aw_hs > 0) && !user_awvalid, 1);
                if (held) check("w_stable", {user_wlast, user_wdata}, hold);
                user_wready = stall ? (cyc % 2 == 1) : 1'b1;
                if (user_wready) begin
                    check("wdata", user_wdata, pat(seed + 32'(beats)));
                    check("wlast", user_wlast, (beats == int'(len)));
                    beats++;
                    held = 0;
                end else begin
                    held = 1;
                    hold = {user_wlast, user_wdata};
                end
            end else user_wready = 1'b0;
            if (user_bready && beats == int'(len) + 1) begin
                user_bvalid = 1'b1; user_bresp = bresp;
            end else begin
                user_bvalid = 1'b0; user_bresp = 2'b00;
            end
            @(negedge clk);
        end
        wr_start = 1'b0; user_wready = 1'b0; user_bvalid = 1'b0;
        if (dones == 0) check("wr_timeout", 0, 1);
        for (int k = 0; k < 6; k++) begin
            if (user_awvalid) aw_hs++;
            if (wr_done) dones++;
            @(negedge clk);
        end
        user_awready = 1'b0;
        check("wr_busy_after_done", wr_busy, 0);
    endtask

    task automatic do_read(input logic [7:0] len, input logic [31:0] addr, input logic [31:0] seed,
                           input bit stall, input int bad_beat, input int last_beat,
                           input int err_beat, output int dones);
        int sent = 0;
        dones = 0;
        @(negedge clk);
        cfg_len = len; cfg_addr = addr; cfg_seed = seed; rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        check("rd_busy_after_start", rd_busy, 1);
        user_arready = 1'b1;
        for (int cyc = 0; cyc < 300 && dones == 0; cyc++) begin
            if (rd_done) dones++;
            if (user_arvalid) begin
                check("araddr", user_araddr, addr);
                check("arlen", user_arlen, len);
            end
            if (user_rready && sent <= last_beat && (!stall || cyc % 2 == 1)) begin
                user_rvalid = 1'b1;
                user_rdata  = pat(seed + 32'(sent)) ^ ((sent == bad_beat) ? DW'(1) : DW'(0));
                user_rlast  = (sent == last_beat);
                user_rresp  = (sent == err_beat) ? 2'b10 : 2'b00;
                sent++;
            end else begin
                user_rvalid = 1'b0; user_rlast = 1'b0; user_rresp = 2'b00;
            end
            @(negedge clk);
        end
        user_rvalid = 1'b0; user_rlast = 1'b0; user_arready = 1'b0;
        if (dones == 0) check("rd_timeout", 0, 1);
        check("rready_dropped", user_rready, 0);
        check("rd_busy_after_done", rd_busy, 0);
        @(negedge clk);
        check("rd_done_single", rd_done, 0);
    endtask

    int beats, aw_hs, dones, rdones, extra;
    logic [1:0] rsp;

    initial begin
        //          rd len  addr          seed          st bad last err bresp beats wresp mis le re
        tv[0]  = '{0, 8'd0, 32'h100,  32'h10,       0, -1, -1, -1, 2'b00, 1, 2'b00, 0, 0, 0};
        tv[1]  = '{0, 8'd3, 32'h200,  32'h10,       1, -1, -1, -1, 2'b00, 4, 2'b00, 0, 0, 0};
        tv[2]  = '{0, 8'd1, 32'h300,  32'hFFFFFFFF, 0, -1, -1, -1, 2'b00, 2, 2'b00, 0, 0, 0};
        tv[3]  = '{0, 8'd2, 32'h400,  32'h55,       1, -1, -1, -1, 2'b10, 3, 2'b10, 0, 0, 0};
        tv[4]  = '{1, 8'd3, 32'h1000, 32'h10,       0, -1,  3, -1, 2'b00, 0, 2'b00, 0, 0, 0};
        tv[5]  = '{1, 8'd3, 32'h1000, 32'h10,       0,  1,  3, -1, 2'b00, 0, 2'b00, 1, 0, 0};
        tv[6]  = '{1, 8'd3, 32'h1100, 32'h20,       0, -1,  1, -1, 2'b00, 0, 2'b00, 0, 1, 0};
        tv[7]  = '{1, 8'd3, 32'h1100, 32'h20,       1, -1,  3, -1, 2'b00, 0, 2'b00, 0, 0, 0};
        tv[8]  = '{1, 8'd3, 32'h1200, 32'h30,       0, -1,  3,  2, 2'b00, 0, 2'b00, 0, 0, 1};
        tv[9]  = '{1, 8'd1, 32'h1300, 32'hFFFFFFFF, 1, -1,  1, -1, 2'b00, 0, 2'b00, 0, 0, 0};
        tv[10] = '{1, 8'd2, 32'h1400, 32'h40,       0, -1,  3, -1, 2'b00, 0, 2'b00, 0, 1, 0};

        repeat (3) @(negedge clk);
        check("rst_wr_busy", wr_busy, 0);
        check("rst_rd_busy", rd_busy, 0);
        check("rst_valids", {user_awvalid, user_wvalid, user_arvalid, user_bready, user_rready}, 0);
        check("rst_status", {wr_done, rd_done, wr_resp, rd_resp_err, rd_len_err, rd_mismatch_cnt}, 0);
        check("awsize", user_awsize, 3'd4);
        check("arsize", user_arsize, 3'd4);
        check("bursts", {user_awburst, user_arburst}, 4'b0101);
        check("wstrb", user_wstrb, 16'hFFFF);
        check("ids", {user_awid, user_wid, user_arid}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            cur_vec = i;
            if (!tv[i].is_rd) begin
                do_write(tv[i].len, tv[i].addr, tv[i].seed, tv[i].stall, tv[i].bresp, 0,
                         beats, aw_hs, rsp, dones);
                check("w_beats", beats, tv[i].exp_beats);
                check("aw_count", aw_hs, 1);
                check("wr_done_count", dones, 1);
                check("wr_resp", rsp, tv[i].exp_wr_resp);
            end else begin
                do_read(tv[i].len, tv[i].addr, tv[i].seed, tv[i].stall, tv[i].bad_beat,
                        tv[i].last_beat, tv[i].err_beat, dones);
                check("rd_done_count", dones, 1);
                check("rd_mismatch_cnt", rd_mismatch_cnt, tv[i].exp_mis);
                check("rd_len_err", rd_len_err, tv[i].exp_len_err);
                check("rd_resp_err", rd_resp_err, tv[i].exp_resp_err);
            end
        end

        // wr_start re-pulsed while busy must not launch a second burst
        cur_vec = 100;
        do_write(8'd1, 32'h500, 32'h70, 0, 2'b00, 1, beats, aw_hs, rsp, dones);
        check("dup_beats", beats, 2);
        check("dup_aw_count", aw_hs, 1);
        check("dup_done_count", dones, 1);

        // simultaneous launches on both engines
        cur_vec = 101;
        fork
            do_write(8'd2, 32'h600, 32'h90, 1, 2'b00, 0, beats, aw_hs, rsp, dones);
            do_read(8'd2, 32'h600, 32'h90, 0, -1, 2, -1, rdones);
        join
        check("sim_wr_done", dones, 1);
        check("sim_wr_beats", beats, 3);
        check("sim_rd_done", rdones, 1);
        check("sim_rd_status", {rd_mismatch_cnt, rd_len_err, rd_resp_err}, 0);

        // reset mid-burst aborts the write engine
        cur_vec = 102;
        @(negedge clk);
        cfg_len = 8'd3; cfg_addr = 32'h700; cfg_seed = 32'h1; wr_start = 1'b1;
        user_awready = 1'b1; user_wready = 1'b0;
        @(negedge clk);
        wr_start = 1'b0;
        for (int k = 0; k < 20 && !user_wvalid; k++) @(negedge clk);
        check("rst_reached_wdata", user_wvalid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_wvalid", user_wvalid, 0);
        check("rst_mid_busy", wr_busy, 0);
        check("rst_mid_aw_b", {user_awvalid, user_bready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        user_wready = 1'b1;
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            if (wr_done || user_wvalid) extra++;
            @(negedge clk);
        end
        check("rst_no_done", extra, 0);
        check("rst_idle", wr_busy, 0);
        user_wready = 1'b0; user_awready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
